// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- round-robin arbiter for the common data bus (CDB).
//
// Several execution units compete for one result broadcast slot per cycle.
// The grant (req_ready) is combinational; the winning tag/data are
// registered and broadcast one cycle after the handshake.
//
// Optional feature: define CDB_ARB_PERF_EN to add the 16-bit saturating
// conflict_count output (cycles with two or more simultaneous requests).
//
// Ports:
//   clock          in   single clock, rising-edge
//   reset_n        in   asynchronous active-low reset
//   flush          in   drop all pending requests this cycle
//   req_valid      in   [NUM_REQ]        per-unit result ready
//   req_tag        in   [NUM_REQ*W]      per-unit ROB tag, unit i at [i*W +: W]
//   req_data       in   [NUM_REQ*32]     per-unit result, unit i at [i*32 +: 32]
//   req_ready      out  [NUM_REQ]        one-hot grant
//   cdb_valid      out  broadcast valid (one-cycle pulse per handshake)
//   cdb_tag        out  [W]              broadcast ROB tag
//   cdb_data       out  [32]             broadcast result
//   conflict_count out  [16]             only with CDB_ARB_PERF_EN
module cdb_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ROB_ADDR_WIDTH = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*32-1:0]              req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               cdb_valid,
  output logic [ROB_ADDR_WIDTH-1:0]          cdb_tag,
  output logic [31:0]                        cdb_data
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [15:0]                        conflict_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      cdb_valid_q, cdb_valid_d;
  logic [ROB_ADDR_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]               cdb_data_q, cdb_data_d;
  logic [NUM_REQ-1:0]        grant_s;
  logic [PTR_W-1:0]          grant_idx_s;
  logic                      handshake_s;

  // Round-robin scan starting at rr_ptr; grant is suppressed during flush
  // and while reset is asserted.
  always_comb begin
    int  idx;
    logic found;
    grant_s     = '0;
    grant_idx_s = '0;
    found       = 1'b0;
    idx         = 0;
    if (!flush && reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end else begin
          idx = idx;
        end
        if (!found && req_valid[idx]) begin
          grant_s[idx] = 1'b1;
          grant_idx_s  = idx[PTR_W-1:0];
          found        = 1'b1;
        end else begin
          found = found;
        end
      end
    end else begin
      found = 1'b0;
    end
  end

  // Grant only ever lands on a valid unit, so any grant bit is a handshake.
  assign handshake_s = |grant_s;
  assign req_ready   = grant_s;

  // Next-state: capture the winner, advance or hold the pointer, and
  // restart the scan from unit 0 on flush.
  always_comb begin
    cdb_valid_d = handshake_s;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (handshake_s) begin
      cdb_tag_d  = req_tag[grant_idx_s*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
      cdb_data_d = req_data[grant_idx_s*32 +: 32];
      if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Broadcast and pointer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= 32'h0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

`ifdef CDB_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;

  // True when two or more units request in the same cycle.
  function automatic logic multi_req(input logic [NUM_REQ-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n = n + int'(v[i]);
    end
    return (n >= 2);
  endfunction

  // Saturating conflict counter; not cleared by flush.
  always_comb begin
    conflict_d = conflict_q;
    if (!flush && multi_req(req_valid) && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= 16'h0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NUM_REQ=3, W=4).
module tb_cdb_arbiter;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
`ifdef CDB_ARB_PERF_EN
  logic [15:0] conflict_count;
`endif

  int total;
  int fails;

  cdb_arbiter #(.NUM_REQ(3), .ROB_ADDR_WIDTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
`ifdef CDB_ARB_PERF_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    total     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 3'b111;
    req_tag   = {4'd3, 4'd2, 4'd1};
    req_data  = {32'h33, 32'h22, 32'h11};

    // Reset: outputs cleared, no grant even with requests present.
    cyc();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_tag",   64'(cdb_tag),   64'd0);
    chk("rst_data",  64'(cdb_data),  64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_ptr",   64'(dut.rr_ptr_q), 64'd0);

    // Release with no requests: stays idle.
    req_valid = 3'b000;
    reset_n   = 1'b1;
    cyc();
    chk("idle_valid", 64'(cdb_valid), 64'd0);

    // Single request on unit 1.
    req_valid = 3'b010;
    req_tag   = {4'd0, 4'd5, 4'd0};
    req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    chk("single_ready", 64'(req_ready), 64'b010);
    cyc();
    req_valid = 3'b000;
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag",   64'(cdb_tag),   64'd5);
    chk("single_data",  64'(cdb_data),  64'hDEADBEEF);
    chk("single_ptr",   64'(dut.rr_ptr_q), 64'd2);
    cyc();
    chk("hold_valid", 64'(cdb_valid), 64'd0);
    chk("hold_tag",   64'(cdb_tag),   64'd5);
    chk("hold_data",  64'(cdb_data),  64'hDEADBEEF);

    // Mid-stream reset discards a registered broadcast.
    req_valid = 3'b010;
    cyc();
    req_valid = 3'b000;
    chk("pre_rst_valid", 64'(cdb_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_tag",   64'(cdb_tag),   64'd0);
    chk("async_rst_ptr",   64'(dut.rr_ptr_q), 64'd0);
    reset_n = 1'b1;

    // Contention from reset: grants 0,1,2 back to back.
    req_tag   = {4'd3, 4'd2, 4'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    req_valid = 3'b111;
    #1;
    chk("cont_ready0", 64'(req_ready), 64'b001);
    cyc();
    chk("cont_tag1",   64'(cdb_tag),   64'd1);
    chk("cont_valid1", 64'(cdb_valid), 64'd1);
    chk("cont_ready1", 64'(req_ready), 64'b010);
    cyc();
    chk("cont_tag2",   64'(cdb_tag),   64'd2);
    chk("cont_valid2", 64'(cdb_valid), 64'd1);
    chk("cont_ready2", 64'(req_ready), 64'b100);
    cyc();
    chk("cont_tag3",  64'(cdb_tag),  64'd3);
    chk("cont_data3", 64'(cdb_data), 64'h33);
    chk("cont_ptr",   64'(dut.rr_ptr_q), 64'd0);

    // Move pointer to 2 via unit 1, then fairness/wrap with 3'b101.
    req_valid = 3'b010;
    cyc();
    chk("pre_wrap_ptr", 64'(dut.rr_ptr_q), 64'd2);
    req_valid = 3'b101;
    #1;
    chk("wrap_ready0", 64'(req_ready), 64'b100);
    cyc();
    chk("wrap_tag0",   64'(cdb_tag),   64'd3);
    chk("wrap_ptr0",   64'(dut.rr_ptr_q), 64'd0);
    chk("wrap_ready1", 64'(req_ready), 64'b001);
    cyc();
    chk("wrap_tag1", 64'(cdb_tag),   64'd1);
    chk("wrap_ptr1", 64'(dut.rr_ptr_q), 64'd1);
    req_valid = 3'b000;
    cyc();
    chk("wrap_idle", 64'(cdb_valid), 64'd0);

    // Flush: in-flight pulse still visible, grant suppressed, pointer to 0.
    req_valid = 3'b010;
    cyc();
    flush     = 1'b1;
    req_valid = 3'b011;
    #1;
    chk("flush_ready",   64'(req_ready), 64'd0);
    chk("flush_inflight", 64'(cdb_valid), 64'd1);
    cyc();
    flush = 1'b0;
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_tag",   64'(cdb_tag),   64'd2);
    chk("flush_ptr",   64'(dut.rr_ptr_q), 64'd0);
    #1;
    chk("post_flush_ready", 64'(req_ready), 64'b001);

    // Single requester granted every cycle regardless of pointer.
    req_valid = 3'b100;
    #1;
    chk("solo_ready0", 64'(req_ready), 64'b100);
    cyc();
    chk("solo_valid0", 64'(cdb_valid), 64'd1);
    chk("solo_ready1", 64'(req_ready), 64'b100);
    cyc();
    chk("solo_valid1", 64'(cdb_valid), 64'd1);
    chk("solo_tag1",   64'(cdb_tag),   64'd3);
    req_valid = 3'b000;
    cyc();

`ifdef CDB_ARB_PERF_EN
    // Perf counter: 4 conflict cycles then 2 single-request cycles.
    reset_n = 1'b0;
    #1;
    chk("perf_rst", 64'(conflict_count), 64'd0);
    reset_n   = 1'b1;
    req_valid = 3'b110;
    for (int i = 0; i < 4; i++) cyc();
    req_valid = 3'b001;
    for (int i = 0; i < 2; i++) cyc();
    chk("perf_count", 64'(conflict_count), 64'd4);
    req_valid = 3'b000;
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of execution units sharing the CDB (2..8).
REQ-002 Parameter ROB_ADDR_WIDTH, default 4: ROB tag width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  pipeline flush; drop all pending requests this cycle.
REQ-006 req_valid  input  NUM_REQ  per-unit result ready for broadcast.
REQ-007 req_tag  input  NUM_REQ*ROB_ADDR_WIDTH  per-unit ROB tag, unit i at bits [i*W +: W].
REQ-008 req_data  input  NUM_REQ*32  per-unit result, unit i at bits [i*32 +: 32].
REQ-009 req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i].
REQ-010 cdb_valid  output  1  broadcast valid.
REQ-011 cdb_tag  output  ROB_ADDR_WIDTH  broadcast ROB tag.
REQ-012 cdb_data  output  32  broadcast result.
REQ-013 conflict_count  output  16  cycles with 2 or more simultaneous requests; present only with CDB_ARB_PERF_EN.

Function
REQ-014 req_ready SHALL be combinational from req_valid, rr_ptr and flush, with at most one bit high.
REQ-015 req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-016 Arbitration SHALL be round-robin: grant the first valid unit found scanning from rr_ptr upward, mod NUM_REQ.
REQ-017 After a handshake on unit g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no handshake, rr_ptr SHALL hold.
REQ-018 The granted tag and data SHALL appear on cdb_tag and cdb_data, with cdb_valid high, exactly one cycle after the handshake.
REQ-019 Each handshake SHALL produce exactly one cdb_valid pulse of one cycle.
REQ-020 Latency from handshake to broadcast SHALL be 1 cycle.
REQ-021 Throughput SHALL be one broadcast per cycle; back-to-back grants SHALL produce back-to-back pulses.
REQ-022 With no handshake in a cycle, cdb_valid SHALL be 0 next cycle; cdb_tag and cdb_data SHALL hold their last values.
REQ-023 Ungranted units keep req_valid, tag and data stable until granted; the arbiter SHALL NOT buffer ungranted requests.
REQ-024 flush high SHALL force req_ready to 0 that cycle, cdb_valid to 0 next cycle, and rr_ptr to 0.
REQ-025 A cdb_valid pulse already registered when flush rises SHALL still be driven in the flush cycle.
REQ-026 With a single requester, it SHALL be granted every cycle it is valid, regardless of rr_ptr.
REQ-027 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-028 No unit SHALL wait more than NUM_REQ-1 grants to other units while continuously valid.

Reset
REQ-029 On reset_n low, without waiting for a clock edge, the following SHALL be cleared:
- cdb_valid=0, cdb_tag=0, cdb_data=0
- rr_ptr=0
- conflict_count=0 when present
REQ-030 During reset, req_ready SHALL be 0.
REQ-031 Reset asserted mid-stream SHALL discard any registered broadcast; the first grant after release SHALL scan from unit 0.

Configuration
REQ-032 Macro CDB_ARB_PERF_EN, when defined, SHALL add conflict_count.
- Increments when at least 2 req_valid bits are high and flush is low.
- Saturates at 16'hFFFF.
- Clears on reset only.
REQ-033 Without CDB_ARB_PERF_EN, the conflict_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset then idle: reset_n=0 -> all outputs 0; release with req_valid=0 -> cdb_valid stays 0.
REQ-035 Single request: req_valid=3'b010, tag1=5, data1=32'hDEADBEEF -> req_ready=3'b010; next cycle cdb_valid=1, cdb_tag=5, cdb_data=32'hDEADBEEF; rr_ptr=2.
REQ-036 Contention from reset: req_valid=3'b111 held for 3 cycles with tags 1,2,3 -> grants in order unit0, unit1, unit2; cdb_tag sequence 1,2,3 on consecutive cycles.
REQ-037 Fairness and wrap: rr_ptr=2, req_valid=3'b101 -> unit2 granted, then unit0; rr_ptr 2->0->1.
REQ-038 Flush: req_valid=3'b011 with flush=1 -> req_ready=0; next cycle cdb_valid=0; rr_ptr=0; a pulse registered the previous cycle is still seen during the flush cycle.
REQ-039 Perf counter (CDB_ARB_PERF_EN defined): 4 cycles with req_valid=3'b110, then 2 cycles with 3'b001 -> conflict_count=4; build without macro compiles with the port absent.
